adder_share_arb: RTL

- Time-multiplexes one WIDTH-bit adder between NREQ independent requesters in the diff-NN core, e.g. the partial-sum producers of parallel PE lanes.
- Uses a round-robin arbiter, one internal adder instance and a single-entry registered response buffer with valid/ready backpressure.
- Results are tagged with the requester index so the downstream demux can route them back.

---
 rtl/adder_share_arb.sv | 104 ++++++++++
 1 files changed

// File: rtl/adder_share_arb.sv
// -----------------------------------------------------------------------------
// adder_share_arb
//   Shares one WIDTH-bit adder among NREQ requesters. A round-robin arbiter
//   picks one valid requester per cycle whenever the single-entry response
//   buffer is free (empty, or being drained this cycle). The winner's sum is
//   registered together with its index so a downstream demux can route it back.
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   req_valid  in   [NREQ]        requester i presents an operand pair
//   req_a      in   [NREQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NREQ*WIDTH]  operand b, same packing
//   req_ready  out  [NREQ]        one-hot grant
//   rsp_valid  out                response buffer holds a result
//   rsp_ready  in                 downstream accepts the response
//   rsp_data   out  [WIDTH]       a + b, mod 2^WIDTH
//   rsp_id     out  [IDW]         index of the producing requester
//   busy       out                rsp_valid | any req_valid
// -----------------------------------------------------------------------------
module adder_share_arb #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    output logic [NREQ-1:0]         req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [$clog2(NREQ)-1:0] rsp_id,
    output logic                    busy
);

    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   win;
    logic [IDW-1:0]   ptr_next;
    logic             found;
    logic             free;
    logic             accept;
    logic [WIDTH-1:0] a_arr [NREQ];
    logic [WIDTH-1:0] b_arr [NREQ];
    logic [WIDTH-1:0] sum;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign a_arr[g] = req_a[g*WIDTH +: WIDTH];
        assign b_arr[g] = req_b[g*WIDTH +: WIDTH];
    end

    // A draining buffer can take a new result in the same cycle, which is
    // what sustains one result per cycle.
    assign free = !rsp_valid || rsp_ready;

    // Round-robin scan starting at ptr; first valid requester wins.
    always_comb begin
        int idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = idx[IDW-1:0];
            end
        end
    end

    // Grant is also masked by reset so no requester sees a handshake while
    // the block is held in reset.
    assign accept = free && found && rst_n;

    always_comb begin
        req_ready = '0;
        if (accept) req_ready[win] = 1'b1;
    end

    assign sum      = a_arr[win] + b_arr[win];
    assign ptr_next = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
    assign busy     = rsp_valid | (|req_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            ptr       <= '0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_data  <= sum;
            rsp_id    <= win;
            ptr       <= ptr_next;
        end else if (rsp_valid && rsp_ready) begin
            // Data and id deliberately hold their last values on drain.
            rsp_valid <= 1'b0;
        end
    end

endmodule
